// File: rtl/id_stage_pkg.sv
// id_stage_pkg: constants shared by the ID stage and its neighbours.
//   - pipeline bus widths (IF->ID, EX->ID, branch bus, ID->EX)
//   - ALU-op one-hot bit positions carried on the ID->EX bus
//   - opcode / funct encodings of the supported instructions
//   - id_to_ex_t: packed layout of the ID->EX bus (first field is the MSB)
package id_stage_pkg;

   localparam int IF_TO_ID_WD = 65;
   localparam int EX_TO_ID_WD = 6;
   localparam int BR_WD       = 33;
   localparam int ALU_OP_WD   = 12;
   localparam int ID_TO_EX_WD = 1 + 32 + 32 + ALU_OP_WD + 5 + 3 + 5 + 32 + 32;

   localparam int ALU_ADD  = 0;
   localparam int ALU_SUB  = 1;
   localparam int ALU_SLT  = 2;
   localparam int ALU_SLTU = 3;
   localparam int ALU_AND  = 4;
   localparam int ALU_NOR  = 5;
   localparam int ALU_OR   = 6;
   localparam int ALU_XOR  = 7;
   localparam int ALU_SLL  = 8;
   localparam int ALU_SRL  = 9;
   localparam int ALU_SRA  = 10;
   localparam int ALU_LUI  = 11;

   localparam logic [5:0] OP_SPECIAL = 6'h00;
   localparam logic [5:0] OP_J       = 6'h02;
   localparam logic [5:0] OP_JAL     = 6'h03;
   localparam logic [5:0] OP_BEQ     = 6'h04;
   localparam logic [5:0] OP_BNE     = 6'h05;
   localparam logic [5:0] OP_ADDIU   = 6'h09;
   localparam logic [5:0] OP_ANDI    = 6'h0c;
   localparam logic [5:0] OP_ORI     = 6'h0d;
   localparam logic [5:0] OP_LUI     = 6'h0f;
   localparam logic [5:0] OP_LW      = 6'h23;
   localparam logic [5:0] OP_SW      = 6'h2b;

   localparam logic [5:0] FN_SLL  = 6'h00;
   localparam logic [5:0] FN_SRL  = 6'h02;
   localparam logic [5:0] FN_JR   = 6'h08;
   localparam logic [5:0] FN_ADDU = 6'h21;
   localparam logic [5:0] FN_SUBU = 6'h23;
   localparam logic [5:0] FN_AND  = 6'h24;
   localparam logic [5:0] FN_OR   = 6'h25;
   localparam logic [5:0] FN_XOR  = 6'h26;
   localparam logic [5:0] FN_SLT  = 6'h2a;
   localparam logic [5:0] FN_SLTU = 6'h2b;

   typedef struct packed {
      logic                 valid;
      logic [31:0]          pc;
      logic [31:0]          inst;
      logic [ALU_OP_WD-1:0] alu_op;
      logic                 src1_sa;
      logic                 src1_pc;
      logic                 src2_imm_sext;
      logic                 src2_imm_zext;
      logic                 src2_8;
      logic                 is_load;
      logic                 is_store;
      logic                 we;
      logic [4:0]           waddr;
      logic [31:0]          rs_data;
      logic [31:0]          rt_data;
   } id_to_ex_t;

   // branch offset: sign-extended imm16 scaled to a byte offset
   function automatic logic [31:0] br_offset(input logic [15:0] imm);
      return {{14{imm[15]}}, imm, 2'b00};
   endfunction

endpackage

// File: rtl/id_stage_decoder_6_64.sv
// decoder_6_64: 6-bit binary to 64-bit one-hot decoder.
// Used by id_stage for both the opcode and the funct field.
// Ports:
//   sel    in  6   binary code
//   onehot out 64  onehot[sel] = 1, all other bits 0
module decoder_6_64 (
   input  logic [5:0]  sel,
   output logic [63:0] onehot
);

   always_comb begin
      onehot = '0;
      for (int i = 0; i < 64; i++) begin
         onehot[i] = (sel == 6'(i));
      end
   end

endmodule

// File: rtl/id_stage.sv
// id_stage: instruction-decode stage of the five-stage SimpleCPU pipeline.
// Owns the IF/ID register, decodes it combinationally, resolves branches and
// jumps, detects load-use hazards against EX and drives the ID->EX bus.
//
// Optional feature macro: ID_LOAD_USE_STALL_EN
//   defined   : load-use detection drives stallreq and suppresses br_e
//   undefined : stallreq = 0, ex_to_id_bus ignored, no branch gating
//
// Ports:
//   clk           in   1    rising-edge clock
//   rst           in   1    synchronous active-high reset
//   flush         in   1    clear IF/ID register
//   stall         in   6    bit1 = hold IF/ID, bit2 = hold ID/EX
//   stallreq      out  1    load-use stall request
//   if_to_id_bus  in   65   {valid, pc, inst}
//   ex_to_id_bus  in   6    {ex_is_load, ex_waddr}
//   raddr1/2      out  5    register-file read addresses (rs, rt)
//   rdata1/2      in   32   forwarded operands
//   br_bus        out  33   {br_e, br_addr}
//   id_to_ex_bus  out  154  see id_to_ex_t
module id_stage
   import id_stage_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'hBFBF_FFFC
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   flush,
   input  logic [5:0]             stall,
   output logic                   stallreq,
   input  logic [IF_TO_ID_WD-1:0] if_to_id_bus,
   input  logic [EX_TO_ID_WD-1:0] ex_to_id_bus,
   output logic [4:0]             raddr1,
   output logic [4:0]             raddr2,
   input  logic [31:0]            rdata1,
   input  logic [31:0]            rdata2,
   output logic [BR_WD-1:0]       br_bus,
   output logic [ID_TO_EX_WD-1:0] id_to_ex_bus
);

   logic        if_id_valid;
   logic [31:0] if_id_pc;
   logic [31:0] if_id_inst;

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         if_id_valid <= 1'b0;
         if_id_pc    <= RESET_PC;
         if_id_inst  <= '0;
      end else if (!stall[1]) begin
         {if_id_valid, if_id_pc, if_id_inst} <= if_to_id_bus;
      end
   end

   logic [5:0]  op;
   logic [4:0]  rs;
   logic [4:0]  rt;
   logic [4:0]  rd;
   logic [5:0]  func;
   logic [15:0] imm;
   logic [63:0] op_d;
   logic [63:0] func_d;

   assign op   = if_id_inst[31:26];
   assign rs   = if_id_inst[25:21];
   assign rt   = if_id_inst[20:16];
   assign rd   = if_id_inst[15:11];
   assign func = if_id_inst[5:0];
   assign imm  = if_id_inst[15:0];

   decoder_6_64 u_op_dec (
      .sel    (op),
      .onehot (op_d)
   );

   decoder_6_64 u_func_dec (
      .sel    (func),
      .onehot (func_d)
   );

   logic is_special;
   logic inst_addu, inst_subu, inst_and, inst_or, inst_xor, inst_slt, inst_sltu;
   logic inst_sll, inst_srl, inst_jr;
   logic inst_addiu, inst_andi, inst_ori, inst_lui, inst_lw, inst_sw;
   logic inst_beq, inst_bne, inst_j, inst_jal;
   logic rtype_sup;
   logic supported;

   assign is_special = op_d[OP_SPECIAL];
   assign inst_addu  = is_special & func_d[FN_ADDU];
   assign inst_subu  = is_special & func_d[FN_SUBU];
   assign inst_and   = is_special & func_d[FN_AND];
   assign inst_or    = is_special & func_d[FN_OR];
   assign inst_xor   = is_special & func_d[FN_XOR];
   assign inst_slt   = is_special & func_d[FN_SLT];
   assign inst_sltu  = is_special & func_d[FN_SLTU];
   assign inst_sll   = is_special & func_d[FN_SLL];
   assign inst_srl   = is_special & func_d[FN_SRL];
   assign inst_jr    = is_special & func_d[FN_JR];
   assign inst_addiu = op_d[OP_ADDIU];
   assign inst_andi  = op_d[OP_ANDI];
   assign inst_ori   = op_d[OP_ORI];
   assign inst_lui   = op_d[OP_LUI];
   assign inst_lw    = op_d[OP_LW];
   assign inst_sw    = op_d[OP_SW];
   assign inst_beq   = op_d[OP_BEQ];
   assign inst_bne   = op_d[OP_BNE];
   assign inst_j     = op_d[OP_J];
   assign inst_jal   = op_d[OP_JAL];

   assign rtype_sup = inst_addu | inst_subu | inst_and | inst_or | inst_xor
                    | inst_slt | inst_sltu | inst_sll | inst_srl | inst_jr;
   assign supported = rtype_sup | inst_addiu | inst_andi | inst_ori | inst_lui
                    | inst_lw | inst_sw | inst_beq | inst_bne | inst_j | inst_jal;

   // unsupported encodings fall out of every term below and behave as NOPs
   logic [ALU_OP_WD-1:0] alu_op;

   always_comb begin
      alu_op           = '0;
      alu_op[ALU_ADD]  = inst_addu | inst_addiu | inst_lw | inst_sw | inst_jal;
      alu_op[ALU_SUB]  = inst_subu;
      alu_op[ALU_SLT]  = inst_slt;
      alu_op[ALU_SLTU] = inst_sltu;
      alu_op[ALU_AND]  = inst_and | inst_andi;
      alu_op[ALU_OR]   = inst_or | inst_ori;
      alu_op[ALU_XOR]  = inst_xor;
      alu_op[ALU_SLL]  = inst_sll;
      alu_op[ALU_SRL]  = inst_srl;
      alu_op[ALU_LUI]  = inst_lui;
   end

   logic       we_dec;
   logic [4:0] waddr;
   logic       rs_used;
   logic       rt_used;

   assign we_dec  = supported & ~(inst_sw | inst_beq | inst_bne | inst_j | inst_jr);
   assign waddr   = inst_jal ? 5'd31 : (is_special ? rd : rt);
   assign rs_used = supported & ~(inst_sll | inst_srl | inst_lui | inst_j | inst_jal);
   assign rt_used = rtype_sup | inst_sw | inst_beq | inst_bne;

   assign raddr1 = rs;
   assign raddr2 = rt;

   logic ex_is_load;
   logic [4:0] ex_waddr;
   logic load_use;
   logic br_block;

   assign {ex_is_load, ex_waddr} = ex_to_id_bus;

`ifdef ID_LOAD_USE_STALL_EN
   assign load_use = if_id_valid & ex_is_load & (ex_waddr != 5'd0)
                   & (((ex_waddr == rs) & rs_used) | ((ex_waddr == rt) & rt_used));
   assign br_block = load_use;
`else
   logic unused_ex;
   assign unused_ex = ex_is_load ^ (^ex_waddr) ^ rs_used;
   assign load_use  = 1'b0;
   assign br_block  = 1'b0;
`endif

   assign stallreq = load_use;

   logic [31:0] pc_plus4;
   logic [31:0] br_target;
   logic        br_take;
   logic        br_e;

   assign pc_plus4 = if_id_pc + 32'd4;

   always_comb begin
      br_target = '0;
      if (inst_beq | inst_bne) begin
         br_target = pc_plus4 + br_offset(imm);
      end else if (inst_j | inst_jal) begin
         br_target = {pc_plus4[31:28], if_id_inst[25:0], 2'b00};
      end else if (inst_jr) begin
         br_target = rdata1;
      end
   end

   assign br_take = (inst_beq & (rdata1 == rdata2))
                  | (inst_bne & (rdata1 != rdata2))
                  | inst_j | inst_jal | inst_jr;
   assign br_e    = if_id_valid & br_take & ~br_block;
   assign br_bus  = {br_e, br_e ? br_target : 32'd0};

   // stall[1] without stall[2]: IF/ID is held but EX must not see the
   // held instruction twice, so emit a bubble
   logic      out_valid;
   id_to_ex_t bus_s;

   assign out_valid = if_id_valid & ~(stall[1] & ~stall[2]);

   always_comb begin
      bus_s               = '0;
      bus_s.valid         = out_valid;
      bus_s.pc            = if_id_pc;
      bus_s.inst          = if_id_inst;
      bus_s.alu_op        = alu_op;
      bus_s.src1_sa       = inst_sll | inst_srl;
      bus_s.src1_pc       = inst_jal;
      bus_s.src2_imm_sext = inst_addiu | inst_lw | inst_sw;
      bus_s.src2_imm_zext = inst_andi | inst_ori | inst_lui;
      bus_s.src2_8        = inst_jal;
      bus_s.is_load       = inst_lw;
      bus_s.is_store      = inst_sw;
      bus_s.we            = we_dec & out_valid;
      bus_s.waddr         = waddr;
      bus_s.rs_data       = rdata1;
      bus_s.rt_data       = rdata2;
   end

   assign id_to_ex_bus = bus_s;

   logic unused_stall;
   assign unused_stall = stall[0] ^ stall[3] ^ stall[4] ^ stall[5];

endmodule
